// File: rtl/sha1_msg_feeder.sv
// Host-side SHA-1 message feeder: pads a byte stream into 512-bit blocks,
// drives a start/busy compression core, adds its result and emits the digest.
// Ports: clk, reset (sync, active high); in_valid/in_ready/in_data/in_last
// byte stream; core_start/core_busy/core_msg/core_state/core_hash core side;
// digest_valid/digest_ready/digest result.
// Optional: define SHA1_FEEDER_MIDSTATE_EN for iv_load/iv_in midstate preload.
// LEN_W: byte counter width, 1..60.
module sha1_msg_feeder #(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         core_start,
  input  logic         core_busy,
  output logic [511:0] core_msg,
  output logic [159:0] core_state,
  input  logic [159:0] core_hash,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [159:0] digest
`ifdef SHA1_FEEDER_MIDSTATE_EN
  ,
  input  logic         iv_load,
  input  logic [159:0] iv_in
`endif
);

  localparam logic [159:0] IV =
    160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FILL,
    S_PAD,
    S_LEN,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t           state;
  logic [159:0]     h;
  logic [159:0]     h_sum;
  logic [6:0]       bi;
  logic [LEN_W-1:0] len;
  logic             fin;
  logic             more_pad;
  logic             pend80;
  logic [8:0]       wpos;
  logic [63:0]      bitlen;

  // Byte bi lands in word bi/4, most significant byte first.
  assign wpos = {bi[5:2], ~bi[1:0], 3'b000};

`ifdef SHA1_FEEDER_MIDSTATE_EN
  logic pre;
  // A preloaded midstate stands for one already-hashed 64-byte block.
  assign bitlen = {{(61-LEN_W){1'b0}}, len, 3'b000}
                + (pre ? 64'd512 : 64'd0);
`else
  assign bitlen = {{(61-LEN_W){1'b0}}, len, 3'b000};
`endif

  assign core_state = h;

  always_comb begin
    h_sum = '0;
    for (int k = 0; k < 5; k++) begin
      h_sum[32*k +: 32] = h[32*k +: 32] + core_hash[32*k +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      h            <= IV;
      core_msg     <= '0;
      bi           <= '0;
      len          <= '0;
      fin          <= 1'b0;
      more_pad     <= 1'b0;
      pend80       <= 1'b0;
      in_ready     <= 1'b0;
      core_start   <= 1'b0;
      digest_valid <= 1'b0;
      digest       <= '0;
`ifdef SHA1_FEEDER_MIDSTATE_EN
      pre          <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
`ifdef SHA1_FEEDER_MIDSTATE_EN
          h   <= iv_load ? iv_in : IV;
          pre <= iv_load;
`else
          h   <= IV;
`endif
          core_msg <= '0;
          bi       <= '0;
          len      <= '0;
          fin      <= 1'b0;
          more_pad <= 1'b0;
          pend80   <= 1'b0;
          in_ready <= 1'b1;
          state    <= S_FILL;
        end
        S_FILL: begin
          if (in_valid && in_ready) begin
            core_msg[wpos +: 8] <= in_data;
            bi  <= bi + 7'd1;
            len <= len + LEN_W'(1);
            if (bi == 7'd63) begin
              // Block full: the 0x80 marker (if last) opens the next one.
              in_ready   <= 1'b0;
              pend80     <= in_last;
              core_start <= 1'b1;
              state      <= S_ISSUE;
            end else if (in_last) begin
              in_ready <= 1'b0;
              state    <= S_PAD;
            end
          end
        end
        S_PAD: begin
          // Block is pre-cleared, so only the marker byte is written.
          core_msg[wpos +: 8] <= 8'h80;
          bi     <= bi + 7'd1;
          pend80 <= 1'b0;
          if (bi <= 7'd55) begin
            state <= S_LEN;
          end else begin
            more_pad   <= 1'b1;
            core_start <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_LEN: begin
          core_msg[511:448] <= {bitlen[31:0], bitlen[63:32]};
          fin        <= 1'b1;
          core_start <= 1'b1;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (core_busy) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!core_busy) state <= S_ACCUM;
        end
        S_ACCUM: begin
          h        <= h_sum;
          core_msg <= '0;
          bi       <= '0;
          if (fin) begin
            digest       <= h_sum;
            digest_valid <= 1'b1;
            state        <= S_DONE;
          end else if (pend80) begin
            state <= S_PAD;
          end else if (more_pad) begin
            more_pad <= 1'b0;
            state    <= S_LEN;
          end else begin
            in_ready <= 1'b1;
            state    <= S_FILL;
          end
        end
        S_DONE: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_msg_feeder.sv
// Self-checking bench for sha1_msg_feeder with a behavioural core model
// and a byte-level SHA-1 reference.
module tb_sha1_msg_feeder;

  typedef logic [7:0] bq_t[$];

  localparam logic [159:0] IV =
    160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         core_start;
  logic         core_busy = 1'b0;
  logic [511:0] core_msg;
  logic [159:0] core_state;
  logic [159:0] core_hash = '0;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic [159:0] digest;
`ifdef SHA1_FEEDER_MIDSTATE_EN
  logic         iv_load = 1'b0;
  logic [159:0] iv_in = IV;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int stab_err = 0;
  logic [511:0] blocks[$];

  always #5 clk = ~clk;

  sha1_msg_feeder #(.LEN_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .core_start(core_start),
    .core_busy(core_busy),
    .core_msg(core_msg),
    .core_state(core_state),
    .core_hash(core_hash),
    .digest_valid(digest_valid),
    .digest_ready(digest_ready),
    .digest(digest)
`ifdef SHA1_FEEDER_MIDSTATE_EN
    ,
    .iv_load(iv_load),
    .iv_in(iv_in)
`endif
  );

  function automatic logic [159:0] sha1_comp(
    input logic [159:0] st, input logic [511:0] m);
    logic [31:0] w[80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = m[32*i +: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, b, c, d, e} = st;
    for (int i = 0; i < 80; i++) begin
      if (i < 20) begin
        f = (b & c) | (~b & d); k = 32'h5a827999;
      end else if (i < 40) begin
        f = b ^ c ^ d; k = 32'h6ed9eba1;
      end else if (i < 60) begin
        f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc;
      end else begin
        f = b ^ c ^ d; k = 32'hca62c1d6;
      end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {a, b, c, d, e};
  endfunction

  function automatic logic [159:0] sha1_ref(
    input bq_t m, input logic [159:0] iv, input logic [63:0] extra);
    bq_t p;
    logic [63:0]  bl;
    logic [159:0] h, c;
    logic [511:0] blk;
    p = m;
    bl = 64'(m.size()) * 64'd8 + extra;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    h = iv;
    for (int n = 0; n < p.size() / 64; n++) begin
      for (int i = 0; i < 64; i++)
        blk[32*(i/4) + 8*(3-i%4) +: 8] = p[64*n+i];
      c = sha1_comp(h, blk);
      for (int j = 0; j < 5; j++) h[32*j +: 32] += c[32*j +: 32];
    end
    return h;
  endfunction

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t rnd_q(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Core model: busy rises the cycle after start, falls after a random
  // latency with the un-added compression result.
  initial begin
    logic [511:0] cm;
    logic [159:0] cs;
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        core_busy = 1'b0;
        cnt = 0;
      end else if (core_busy) begin
        if (core_msg !== cm || core_state !== cs) stab_err++;
        if (core_start) stab_err++;
        if (cnt == 0) begin
          core_hash = sha1_comp(cs, cm);
          core_busy = 1'b0;
        end else begin
          cnt--;
        end
      end else if (core_start) begin
        cm = core_msg;
        cs = core_state;
        blocks.push_back(core_msg);
        cnt = $urandom_range(1, 5);
        core_busy = 1'b1;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_msg(input bq_t m, input bit gaps, output bit to);
    int i, guard;
    bit tog, hs;
    i = 0; guard = 0; tog = 1'b0; to = 1'b0;
    while (i < m.size()) begin
      tog = ~tog;
      in_valid = gaps ? tog : 1'b1;
      in_data = m[i];
      in_last = (i == m.size() - 1);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
      if (guard > 10000) begin
        to = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic get_digest(input int hold, output logic [159:0] d,
                            output bit to, output int bad);
    int guard;
    guard = 0; to = 1'b0; bad = 0; d = '0;
    digest_ready = 1'b0;
    while (!digest_valid) begin
      if (in_ready) bad++;
      @(posedge clk); #1;
      guard++;
      if (guard > 3000) begin
        to = 1'b1;
        break;
      end
    end
    if (!to) begin
      d = digest;
      for (int c = 0; c < hold; c++) begin
        @(posedge clk); #1;
        if (!digest_valid || digest !== d || in_ready) bad++;
      end
      digest_ready = 1'b1;
      @(posedge clk); #1;
      digest_ready = 1'b0;
      if (digest_valid) bad++;
    end
  endtask

  task automatic run_msg(input bq_t m, input bit gaps, input int hold,
                         output logic [159:0] d, output bit to,
                         output int bad);
    bit t1, t2;
    blocks.delete();
    send_msg(m, gaps, t1);
    get_digest(hold, d, t2, bad);
    to = t1 | t2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready);
    end
    n_chk++;
    if (core_start !== 1'b0) begin
      n_fail++; $display("FAIL rst_core_start: got %b want 0", core_start);
    end
    n_chk++;
    if (digest_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_dvalid: got %b want 0", digest_valid);
    end
    n_chk++;
    if (core_msg !== '0) begin
      n_fail++; $display("FAIL rst_core_msg: got %h want 0", core_msg);
    end
    n_chk++;
    if (digest !== '0) begin
      n_fail++; $display("FAIL rst_digest: got %h want 0", digest);
    end
    n_chk++;
    if (core_state !== IV) begin
      n_fail++; $display("FAIL rst_state: got %h want %h", core_state, IV);
    end
    reset = 1'b0;
  endtask

  task automatic test_abc();
    logic [159:0] d;
    bit to;
    int bad;
    run_msg(s2q("abc"), 1'b0, 0, d, to, bad);
    n_chk++;
    if (to || bad != 0) begin
      n_fail++; $display("FAIL abc_flow: got to=%b bad=%0d want 0/0", to, bad);
    end
    n_chk++;
    if (blocks.size() != 1) begin
      n_fail++; $display("FAIL abc_starts: got %0d want 1", blocks.size());
    end else begin
      n_chk++;
      if (blocks[0][31:0] !== 32'h61626380) begin
        n_fail++;
        $display("FAIL abc_w0: got %h want 61626380", blocks[0][31:0]);
      end
      n_chk++;
      if (blocks[0][511:480] !== 32'h18) begin
        n_fail++;
        $display("FAIL abc_w15: got %h want 18", blocks[0][511:480]);
      end
    end
    n_chk++;
    if (d !== 160'ha9993e364706816aba3e25717850c26c9cd0d89d) begin
      n_fail++; $display("FAIL abc_digest: got %h want a9993e36...", d);
    end
  endtask

  task automatic test_hello();
    logic [159:0] d;
    bit to;
    int bad;
    run_msg(s2q("hello world"), 1'b0, 0, d, to, bad);
    n_chk++;
    if (to || bad != 0) begin
      n_fail++; $display("FAIL hw_flow: got to=%b bad=%0d want 0/0", to, bad);
    end
    n_chk++;
    if (blocks.size() != 1) begin
      n_fail++; $display("FAIL hw_starts: got %0d want 1", blocks.size());
    end else begin
      n_chk++;
      if (blocks[0][31:0] !== 32'h68656c6c ||
          blocks[0][95:64] !== 32'h726c6480 ||
          blocks[0][511:480] !== 32'h58) begin
        n_fail++;
        $display("FAIL hw_words: got %h %h %h want 68656c6c 726c6480 58",
                 blocks[0][31:0], blocks[0][95:64], blocks[0][511:480]);
      end
    end
    n_chk++;
    if (d !== 160'h2aae6c35c94fcfb415dbe95f408b9ce91ee846ed) begin
      n_fail++; $display("FAIL hw_digest: got %h want 2aae6c35...", d);
    end
  endtask

  task automatic test_two_block();
    logic [159:0] d;
    logic [511:0] e;
    bit to;
    int bad;
    e = '0;
    e[511:480] = 32'h1c0;
    run_msg(s2q({"abcdbcdecdefdefgefghfghighijhijk",
                 "ijkljklmklmnlmnomnopnopq"}), 1'b0, 0, d, to, bad);
    n_chk++;
    if (to || bad != 0) begin
      n_fail++; $display("FAIL two_flow: got to=%b bad=%0d want 0/0", to, bad);
    end
    n_chk++;
    if (blocks.size() != 2) begin
      n_fail++; $display("FAIL two_starts: got %0d want 2", blocks.size());
    end else begin
      n_chk++;
      if (blocks[1] !== e) begin
        n_fail++; $display("FAIL two_blk1: got %h want %h", blocks[1], e);
      end
    end
    n_chk++;
    if (d !== 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1) begin
      n_fail++; $display("FAIL two_digest: got %h want 84983e44...", d);
    end
  endtask

  task automatic test_boundaries();
    int lens[10] = '{1, 54, 55, 56, 63, 64, 65, 119, 120, 128};
    logic [159:0] d, r;
    bit to;
    int bad, nb;
    bq_t m;
    for (int n = 0; n < 10; n++) begin
      m = rnd_q(lens[n]);
      r = sha1_ref(m, IV, 64'd0);
      nb = (lens[n] + 8) / 64 + 1;
      run_msg(m, 1'b0, 0, d, to, bad);
      n_chk++;
      if (to || bad != 0 || d !== r) begin
        n_fail++;
        $display("FAIL bnd_len%0d: got %h to=%b bad=%0d want %h",
                 lens[n], d, to, bad, r);
      end
      n_chk++;
      if (blocks.size() != nb) begin
        n_fail++;
        $display("FAIL bnd_blocks%0d: got %0d want %0d",
                 lens[n], blocks.size(), nb);
      end else if (lens[n] % 64 == 0) begin
        n_chk++;
        if (blocks[lens[n]/64][31:0] !== 32'h80000000) begin
          n_fail++;
          $display("FAIL bnd_marker%0d: got %h want 80000000",
                   lens[n], blocks[lens[n]/64][31:0]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [159:0] d, r;
    bit to;
    int bad;
    bq_t m;
    for (int n = 0; n < 8; n++) begin
      m = rnd_q($urandom_range(1, 200));
      r = sha1_ref(m, IV, 64'd0);
      run_msg(m, 1'($urandom), $urandom_range(0, 4), d, to, bad);
      n_chk++;
      if (to || bad != 0 || d !== r) begin
        n_fail++;
        $display("FAIL rnd%0d len%0d: got %h to=%b bad=%0d want %h",
                 n, m.size(), d, to, bad, r);
      end
    end
  endtask

  task automatic test_gaps_hold();
    logic [159:0] d1, d2, r;
    bit to1, to2;
    int bad1, bad2;
    bq_t m;
    m = rnd_q(40);
    r = sha1_ref(m, IV, 64'd0);
    run_msg(m, 1'b0, 0, d1, to1, bad1);
    run_msg(m, 1'b1, 20, d2, to2, bad2);
    n_chk++;
    if (to2 || bad2 != 0) begin
      n_fail++;
      $display("FAIL gap_hold: got to=%b bad=%0d want 0/0", to2, bad2);
    end
    n_chk++;
    if (to1 || d2 !== d1 || d2 !== r) begin
      n_fail++;
      $display("FAIL gap_digest: got %h gapless %h want %h", d2, d1, r);
    end
  endtask

  task automatic test_reset_mid();
    logic [159:0] d;
    bit to, hs;
    int bad, i, guard;
    bq_t m;
    m = rnd_q(100);
    blocks.delete();
    i = 0; guard = 0;
    while (i < 64 && guard < 2000) begin
      in_valid = 1'b1;
      in_data = m[i];
      in_last = 1'b0;
      hs = in_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    in_valid = 1'b0;
    while (!core_busy && guard < 4000) begin
      @(posedge clk); #1;
      guard++;
    end
    n_chk++;
    if (!core_busy) begin
      n_fail++; $display("FAIL mid_busy: got 0 want 1");
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (in_ready !== 1'b0 || core_start !== 1'b0 ||
        digest_valid !== 1'b0 || core_msg !== '0 ||
        digest !== '0 || core_state !== IV) begin
      n_fail++;
      $display("FAIL mid_rst: got rdy=%b st=%b dv=%b msg0=%b dg=%h want 0s",
               in_ready, core_start, digest_valid,
               core_msg == '0, digest);
    end
    reset = 1'b0;
    run_msg(s2q("abc"), 1'b0, 0, d, to, bad);
    n_chk++;
    if (to || bad != 0 ||
        d !== 160'ha9993e364706816aba3e25717850c26c9cd0d89d) begin
      n_fail++;
      $display("FAIL mid_abc: got %h to=%b bad=%0d want a9993e36...",
               d, to, bad);
    end
  endtask

`ifdef SHA1_FEEDER_MIDSTATE_EN
  task automatic test_midstate();
    logic [159:0] d, r;
    bit to;
    int bad;
    reset = 1'b1;
    iv_load = 1'b1;
    iv_in = IV;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    iv_load = 1'b0;
    r = sha1_ref(s2q("abc"), IV, 64'd512);
    run_msg(s2q("abc"), 1'b0, 0, d, to, bad);
    n_chk++;
    if (blocks.size() != 1 || blocks[0][511:480] !== 32'h218) begin
      n_fail++;
      $display("FAIL ms_len: got n=%0d w15=%h want 1/218",
               blocks.size(), blocks[0][511:480]);
    end
    n_chk++;
    if (to || bad != 0 || d !== r) begin
      n_fail++; $display("FAIL ms_digest: got %h want %h", d, r);
    end
  endtask
`endif

  task automatic test_core_if();
    n_chk++;
    if (stab_err != 0) begin
      n_fail++;
      $display("FAIL core_if: got %0d unstable/restart events want 0",
               stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_hello();
    test_two_block();
    test_boundaries();
    test_random();
    test_gaps_hold();
    test_reset_mid();
`ifdef SHA1_FEEDER_MIDSTATE_EN
    test_midstate();
`endif
    test_core_if();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
